// File: rtl/round_robin_dispatch.sv
// round_robin_dispatch
//
// Front end of the put_in_order reorder stage. A single valid/ready stream is
// issued to N_LANES variable-latency worker lanes in strict round-robin order
// (0, 1, ..., N_LANES-1, 0, ...). Each lane stays busy from issue until it
// pulses lane_done. The next lane in sequence must be free before another item
// is accepted, so the issue order always matches the order put_in_order
// drains the lanes in.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   up_vld     upstream item valid
//   up_rdy     dispatcher can accept this cycle (combinational: ~busy[ptr])
//   up_data    upstream item
//   lane_vlds  one-hot issue strobe, registered, high for one cycle per issue
//   lane_data  per-lane item, registered, held after issue
//   lane_done  per-lane completion pulse
//   busy       lane holds an issued, uncompleted item
//   in_flight  number of busy lanes, kept as a registered counter
//   err        sticky protocol error: lane_done on a lane that is not busy

module round_robin_dispatch #(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned N_LANES = 10,
  localparam int unsigned CNT_W   = $clog2(N_LANES + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            up_vld,
  output logic                            up_rdy,
  input  logic [WIDTH-1:0]                up_data,
  output logic [N_LANES-1:0]              lane_vlds,
  output logic [N_LANES-1:0][WIDTH-1:0]   lane_data,
  input  logic [N_LANES-1:0]              lane_done,
  output logic [N_LANES-1:0]              busy,
  output logic [CNT_W-1:0]                in_flight,
  output logic                            err
);

  localparam int unsigned PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [PTR_W-1:0]   ptr;
  logic               accept;
  logic [N_LANES-1:0] issue_sel;
  logic [N_LANES-1:0] retire;
  logic               spurious;
  logic [CNT_W-1:0]   retire_cnt;
  logic [N_LANES-1:0] busy_next;
  logic [CNT_W-1:0]   in_flight_next;
  logic [PTR_W-1:0]   ptr_next;

  // Only the lane at ptr is ever eligible; a done in this same cycle does not bypass.
  assign up_rdy = ~busy[ptr];
  assign accept = up_vld & up_rdy;

  // One-hot select of the lane receiving this cycle's accept.
  always_comb begin
    issue_sel = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      issue_sel[i] = accept && (ptr == PTR_W'(i));
    end
  end

  // Completions on busy lanes retire; completions on idle lanes are protocol errors.
  assign retire   = lane_done & busy;
  assign spurious = |(lane_done & ~busy);

  // Number of lanes retiring this cycle; several may complete together.
  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      retire_cnt = retire_cnt + CNT_W'(retire[i]);
    end
  end

  // Issue sets after retire clears, so an accept into lane i always leaves it busy.
  assign busy_next      = (busy & ~retire) | issue_sel;
  assign in_flight_next = in_flight + CNT_W'(accept) - retire_cnt;
  assign ptr_next       = (ptr == PTR_W'(N_LANES - 1)) ? '0 : ptr + PTR_W'(1);

  // Round-robin pointer: advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // Lane tracking state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      busy      <= busy_next;
      in_flight <= in_flight_next;
      err       <= err | spurious;
    end
  end

  // Issue strobe, one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_vlds <= '0;
    end else begin
      lane_vlds <= issue_sel;
    end
  end

  // Lane payload: written only on accept so idle-cycle up_data never enters state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_data <= '0;
    end else begin
      for (int i = 0; i < int'(N_LANES); i++) begin
        if (issue_sel[i]) begin
          lane_data[i] <= up_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_robin_dispatch.sv
// tb_round_robin_dispatch
//
// Directed checks on a 4-lane dispatcher (dut_a) against a small reference
// model, followed by a 10-lane random soak (dut_b) with bench-side worker
// lanes and an in-order drain that stands in for put_in_order.

module tb_round_robin_dispatch;

  logic clk;
  logic rst_n;

  // 4-lane instance
  logic             up_vld_a;
  logic             up_rdy_a;
  logic [7:0]       up_data_a;
  logic [3:0]       lane_vlds_a;
  logic [3:0][7:0]  lane_data_a;
  logic [3:0]       lane_done_a;
  logic [3:0]       busy_a;
  logic [2:0]       in_flight_a;
  logic             err_a;

  // 10-lane instance
  logic             up_vld_b;
  logic             up_rdy_b;
  logic [7:0]       up_data_b;
  logic [9:0]       lane_vlds_b;
  logic [9:0][7:0]  lane_data_b;
  logic [9:0]       lane_done_b;
  logic [9:0]       busy_b;
  logic [3:0]       in_flight_b;
  logic             err_b;

  round_robin_dispatch #(.WIDTH(8), .N_LANES(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_vld    (up_vld_a),
    .up_rdy    (up_rdy_a),
    .up_data   (up_data_a),
    .lane_vlds (lane_vlds_a),
    .lane_data (lane_data_a),
    .lane_done (lane_done_a),
    .busy      (busy_a),
    .in_flight (in_flight_a),
    .err       (err_a)
  );

  round_robin_dispatch #(.WIDTH(8), .N_LANES(10)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_vld    (up_vld_b),
    .up_rdy    (up_rdy_b),
    .up_data   (up_data_b),
    .lane_vlds (lane_vlds_b),
    .lane_data (lane_data_b),
    .lane_done (lane_done_b),
    .busy      (busy_b),
    .in_flight (in_flight_b),
    .err       (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_a[$];
  logic [7:0] sb_b[$];
  logic [7:0] res_q[10][$];

  // Reference state for dut_a: value expected after the next rising edge.
  logic [3:0] m_busy;
  logic [1:0] m_ptr;
  logic       m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_ptr  = '0;
    m_err  = 1'b0;
    sb_a.delete();
  endtask

  // Apply one cycle of inputs to dut_a and advance the model.
  task automatic drive_a(input logic vld, input logic [7:0] data, input logic [3:0] done);
    logic       acc;
    logic [3:0] nb;
    exp_t       e;
    up_vld_a    = vld;
    up_data_a   = data;
    lane_done_a = done;
    chk("up_rdy", up_rdy_a, !m_busy[m_ptr]);
    acc   = vld && !m_busy[m_ptr];
    m_err = m_err | (|(done & ~m_busy));
    nb    = m_busy & ~done;
    if (acc) begin
      e.lane = m_ptr;
      e.data = data;
      sb_a.push_back(e);
      nb[m_ptr] = 1'b1;
      m_ptr = (m_ptr == 2'd3) ? 2'd0 : m_ptr + 2'd1;
    end
    m_busy = nb;
  endtask

  // Compare dut_a outputs against the scoreboard and model.
  task automatic mon_a();
    exp_t       e;
    logic [3:0] ev;
    if (sb_a.size() > 0) begin
      e  = sb_a.pop_front();
      ev = 4'(1) << e.lane;
      chk("strobe", lane_vlds_a, ev);
      chk("lane_data", lane_data_a[e.lane], e.data);
    end else begin
      chk("no_strobe", lane_vlds_a, 4'b0000);
    end
    chk("busy", busy_a, m_busy);
    chk("in_flight", in_flight_a, $countones(m_busy));
    chk("cnt_eq_busy", in_flight_a, $countones(busy_a));
    chk("err", err_a, m_err);
  endtask

  task automatic cyc(input logic vld, input logic [7:0] data, input logic [3:0] done);
    drive_a(vld, data, done);
    tick();
    mon_a();
  endtask

  int         sent;
  int         got;
  int         cyc_n;
  int         optr;
  int         w_cnt[10];
  bit         w_act[10];
  logic [7:0] w_dat[10];
  logic [9:0] d;
  logic [7:0] v;

  initial begin
    rst_n       = 1'b1;
    up_vld_a    = 1'b0;
    up_data_a   = '0;
    lane_done_a = '0;
    up_vld_b    = 1'b0;
    up_data_b   = '0;
    lane_done_b = '0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy_a, 4'b0);
    chk("rst_vlds", lane_vlds_a, 4'b0);
    chk("rst_cnt", in_flight_a, 3'd0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_rdy", up_rdy_a, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back issue, each lane completing the cycle after its strobe.
    cyc(1'b1, 8'h00, 4'b0000);
    cyc(1'b1, 8'h01, 4'b0001);
    cyc(1'b1, 8'h02, 4'b0010);
    cyc(1'b1, 8'h03, 4'b0100);
    cyc(1'b0, 8'h00, 4'b1000);

    // Fill all lanes, then complete out of order 2,1,3 and finally 0.
    cyc(1'b1, 8'h10, 4'b0000);
    cyc(1'b1, 8'h11, 4'b0000);
    cyc(1'b1, 8'h12, 4'b0000);
    cyc(1'b1, 8'h13, 4'b0000);
    chk("full_cnt", in_flight_a, 3'd4);
    chk("full_rdy", up_rdy_a, 1'b0);
    cyc(1'b1, 8'h04, 4'b0100);
    chk("ooo_cnt3", in_flight_a, 3'd3);
    chk("ooo_rdy3", up_rdy_a, 1'b0);
    cyc(1'b1, 8'h04, 4'b0010);
    chk("ooo_cnt2", in_flight_a, 3'd2);
    chk("ooo_rdy2", up_rdy_a, 1'b0);
    cyc(1'b1, 8'h04, 4'b1000);
    chk("ooo_cnt1", in_flight_a, 3'd1);
    chk("ooo_rdy1", up_rdy_a, 1'b0);
    cyc(1'b1, 8'h04, 4'b0001);
    chk("rdy_after_done0", up_rdy_a, 1'b1);
    cyc(1'b1, 8'h04, 4'b0000);
    chk("item04_lane0", lane_data_a[0], 8'h04);
    cyc(1'b0, 8'h00, 4'b0000);

    // Spurious completion on idle lane 3 raises a sticky error.
    cyc(1'b0, 8'h00, 4'b1000);
    chk("err_set", err_a, 1'b1);
    chk("err_busy_kept", busy_a, 4'b0001);
    cyc(1'b0, 8'h00, 4'b0000);
    chk("err_sticky", err_a, 1'b1);

    // Accept into lane 1 alongside a done for idle lane 1: the accept wins.
    cyc(1'b1, 8'h06, 4'b0010);
    chk("acc_wins", busy_a[1], 1'b1);
    cyc(1'b1, 8'h07, 4'b0000);
    chk("pre_rst_busy", busy_a, 4'b0111);

    // Asynchronous reset in mid-cycle.
    drive_a(1'b0, 8'h00, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 4'b0);
    chk("mid_rst_vlds", lane_vlds_a, 4'b0);
    chk("mid_rst_data", lane_data_a, 32'h0);
    chk("mid_rst_cnt", in_flight_a, 3'd0);
    chk("mid_rst_err", err_a, 1'b0);
    chk("mid_rst_rdy", up_rdy_a, 1'b1);
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    mon_a();
    cyc(1'b1, 8'h08, 4'b0000);
    chk("post_rst_lane0", lane_vlds_a, 4'b0001);
    cyc(1'b0, 8'h00, 4'b0010);
    chk("stale_done_err", err_a, 1'b1);
    cyc(1'b0, 8'h00, 4'b0001);
    cyc(1'b0, 8'h00, 4'b0000);

    // Random soak on the 10-lane instance.
    up_vld_a    = 1'b0;
    lane_done_a = '0;
    sent  = 0;
    got   = 0;
    cyc_n = 0;
    optr  = 0;
    for (int i = 0; i < 10; i++) begin
      w_act[i] = 1'b0;
      w_cnt[i] = 0;
      w_dat[i] = '0;
    end
    while (got < 1000 && cyc_n < 30000) begin
      d = '0;
      for (int i = 0; i < 10; i++) begin
        if (lane_vlds_b[i]) begin
          w_act[i] = 1'b1;
          w_dat[i] = lane_data_b[i];
          w_cnt[i] = int'($urandom_range(0, 9));
        end
      end
      for (int i = 0; i < 10; i++) begin
        if (w_act[i]) begin
          if (w_cnt[i] == 0) begin
            d[i]     = 1'b1;
            w_act[i] = 1'b0;
            res_q[i].push_back(w_dat[i]);
          end else begin
            w_cnt[i]--;
          end
        end
      end
      while (res_q[optr].size() > 0) begin
        v = res_q[optr].pop_front();
        if (sb_b.size() > 0) begin
          chk("order", v, sb_b.pop_front());
        end else begin
          chk("order_extra", {1'b0, v}, 9'h100);
        end
        got++;
        optr = (optr == 9) ? 0 : optr + 1;
      end
      chk("b_cnt_eq_busy", in_flight_b, $countones(busy_b));
      lane_done_b = d;
      up_vld_b    = (sent < 1000) && ($urandom_range(0, 99) < 80);
      up_data_b   = 8'($urandom);
      if (up_vld_b && up_rdy_b) begin
        sb_b.push_back(up_data_b);
        sent++;
      end
      tick();
      cyc_n++;
    end
    up_vld_b    = 1'b0;
    lane_done_b = '0;
    chk("soak_done", got, 1000);
    chk("soak_err", err_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
